// File: rtl/mpc_mac_pipe_dsp_pkg.sv
// Shared sizing rules and output clamp helper for the MPC DSP multiply/MAC pipe.
package mpc_dsp_pkg;

  localparam int LAT_BASE = 4;
  localparam int SAT_W    = 128;

  // Accumulator width: guard bits only matter when products are summed.
  function automatic int acc_w(input int a_w, input int b_w, input bit mac_en, input int guard);
    return mac_en ? a_w + b_w + guard : a_w + b_w;
  endfunction

  // Width of an operand once it is expressed as a signed value.
  function automatic int ext_w(input int width, input bit is_signed);
    return is_signed ? width : width + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] value,
                                                       input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/mpc_mac_pipe_dsp_if.sv
// Sample/result bundle between the MPC datapath and the DSP multiply/MAC pipe.
interface mpc_mac_pipe_dsp_if #(
  parameter int A_W   = 21,
  parameter int B_W   = 14,
  parameter int OUT_W = 35
);
  logic                    ce;
  logic                    in_valid;
  logic [A_W-1:0]          a;
  logic [B_W-1:0]          b;
  logic                    acc_clr;
  logic signed [OUT_W-1:0] p;
  logic                    out_valid;
  logic                    sat;
  logic                    acc_ovf;

  modport master (
    output ce, in_valid, a, b, acc_clr,
    input  p, out_valid, sat, acc_ovf
  );

  modport slave (
    input  ce, in_valid, a, b, acc_clr,
    output p, out_valid, sat, acc_ovf
  );
endinterface

// File: rtl/mpc_mac_pipe_dsp_dly.sv
// N-stage register chain with clock enable and synchronous reset (N >= 1).
module mpc_pipe_dly #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else if (ce) begin
      stage_q[0] <= d;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[N-1];

endmodule

// File: rtl/mpc_mac_pipe_dsp.sv
// Pipelined multiply / multiply-accumulate with round, shift and saturate.
// S1/S2 map onto the DSP A/B and M registers; S3 accumulates; S4 rounds and clamps.
module mpc_mac_pipe_dsp
  import mpc_dsp_pkg::*;
#(
  parameter int A_W      = 21,
  parameter int B_W      = 14,
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b0,
  parameter bit MAC_EN   = 1'b0,
  parameter int GUARD    = 4,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = 35,
  parameter int PIPE_X   = 0
) (
  input logic               clk,
  input logic               rst,
  mpc_mac_pipe_dsp_if.slave bus
);

  localparam int ACC_W  = acc_w(A_W, B_W, MAC_EN, GUARD);
  localparam int PROD_W = A_W + B_W + 1;
  localparam int AX_W   = ext_w(A_W, A_SIGNED);
  localparam int BX_W   = ext_w(B_W, B_SIGNED);
  localparam int R_W    = ACC_W + 1;
  localparam int DW     = OUT_W + 3;
  localparam logic signed [R_W-1:0] RND = R_W'(1) << SHIFT >> 1;

  // S1
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic           v1_q;
  logic           clr1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      clr1_q <= 1'b0;
    end else if (bus.ce) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      v1_q   <= bus.in_valid;
      clr1_q <= bus.in_valid & bus.acc_clr;
    end
  end

  logic signed [AX_W-1:0] a_ext;
  logic signed [BX_W-1:0] b_ext;

  if (A_SIGNED) begin : g_a_sx
    assign a_ext = $signed(a_q);
  end else begin : g_a_zx
    assign a_ext = $signed({1'b0, a_q});
  end

  if (B_SIGNED) begin : g_b_sx
    assign b_ext = $signed(b_q);
  end else begin : g_b_zx
    assign b_ext = $signed({1'b0, b_q});
  end

  logic signed [PROD_W-1:0] a_x;
  logic signed [PROD_W-1:0] b_x;
  assign a_x = PROD_W'(a_ext);
  assign b_x = PROD_W'(b_ext);

  // S2
  logic signed [PROD_W-1:0] prod_q;
  logic                     v2_q;
  logic                     clr2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      v2_q   <= 1'b0;
      clr2_q <= 1'b0;
    end else if (bus.ce) begin
      prod_q <= a_x * b_x;
      v2_q   <= v1_q;
      clr2_q <= clr1_q;
    end
  end

  // S3: a product too wide for a guard-less accumulator also counts as a wrap
  logic signed [ACC_W-1:0] prod_a;
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] acc_q;
  logic                    prod_fits;
  logic                    add_ovf;
  logic                    ovf3_q;
  logic                    v3_q;

  assign prod_a    = ACC_W'(prod_q);
  assign prod_fits = (PROD_W'(prod_a) == prod_q);
  assign sum_d     = acc_q + prod_a;
  assign add_ovf   = (acc_q[ACC_W-1] == prod_a[ACC_W-1]) && (sum_d[ACC_W-1] != acc_q[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      ovf3_q <= 1'b0;
      v3_q   <= 1'b0;
    end else if (bus.ce) begin
      v3_q <= v2_q;
      if (v2_q) begin
        if (!MAC_EN || clr2_q) acc_q <= prod_a;
        else                   acc_q <= sum_d;
        if (!MAC_EN)      ovf3_q <= 1'b0;
        else if (clr2_q)  ovf3_q <= !prod_fits;
        else              ovf3_q <= ovf3_q | add_ovf | !prod_fits;
      end
    end
  end

  // S4: one extra bit keeps the rounding add from wrapping
  logic signed [R_W-1:0]   rnd_sum;
  logic signed [R_W-1:0]   r_sh;
  logic signed [SAT_W-1:0] r_wide;
  logic signed [SAT_W-1:0] clip;
  logic signed [OUT_W-1:0] p_d;
  logic                    sat_d;

  assign rnd_sum = R_W'(acc_q) + RND;
  assign r_sh    = rnd_sum >>> SHIFT;
  assign r_wide  = SAT_W'(r_sh);
  assign clip    = sat_clip(r_wide, OUT_W);
  assign sat_d   = (clip != r_wide);
  assign p_d     = OUT_W'(clip);

  logic signed [OUT_W-1:0] p4_q;
  logic                    sat4_q;
  logic                    ovf4_q;
  logic                    v4_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p4_q   <= '0;
      sat4_q <= 1'b0;
      ovf4_q <= 1'b0;
      v4_q   <= 1'b0;
    end else if (bus.ce) begin
      v4_q <= v3_q;
      if (v3_q) begin
        p4_q   <= p_d;
        sat4_q <= sat_d;
        ovf4_q <= ovf3_q;
      end
    end
  end

  // S4 holds on bubbles, so the plain delay chain also presents the last valid p
  logic [DW-1:0] s4_bus;
  logic [DW-1:0] out_bus;
  assign s4_bus = {p4_q, sat4_q, ovf4_q, v4_q};

  if (PIPE_X > 0) begin : g_pipe
    mpc_pipe_dly #(.W(DW), .N(PIPE_X)) u_dly (
      .clk (clk),
      .rst (rst),
      .ce  (bus.ce),
      .d   (s4_bus),
      .q   (out_bus)
    );
  end else begin : g_nopipe
    assign out_bus = s4_bus;
  end

  assign bus.p         = out_bus[DW-1:3];
  assign bus.sat       = out_bus[2];
  assign bus.acc_ovf   = out_bus[1];
  assign bus.out_valid = out_bus[0];

endmodule

// File: tb/tb_mpc_mac_pipe_dsp.sv
// Three configurations of the DSP pipe driven side by side and compared every cycle
// against an arithmetic reference model with a per-instance expected-result queue.
module tb_mpc_mac_pipe_dsp;
  import mpc_dsp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce;
  logic        vld;
  logic        clr;
  logic [31:0] in_a [3];
  logic [31:0] in_b [3];

  // 0: defaults 21s x 14u multiply; 1: 8x8 signed MAC, no guard, PIPE_X=2; 2: 8x8 signed, SHIFT=4, OUT_W=8
  int c_aw   [3] = '{21, 8, 8};
  int c_bw   [3] = '{14, 8, 8};
  int c_as   [3] = '{1, 1, 1};
  int c_bs   [3] = '{0, 1, 1};
  int c_mac  [3] = '{0, 1, 0};
  int c_accw [3] = '{35, 16, 16};
  int c_sh   [3] = '{0, 0, 4};
  int c_ow   [3] = '{35, 20, 8};
  int c_lat  [3] = '{LAT_BASE + 0, LAT_BASE + 2, LAT_BASE + 1};

  mpc_mac_pipe_dsp_if #(.A_W(21), .B_W(14), .OUT_W(35)) bus0 ();
  mpc_mac_pipe_dsp_if #(.A_W(8),  .B_W(8),  .OUT_W(20)) bus1 ();
  mpc_mac_pipe_dsp_if #(.A_W(8),  .B_W(8),  .OUT_W(8))  bus2 ();

  assign bus0.ce = ce;  assign bus0.in_valid = vld;  assign bus0.acc_clr = clr;
  assign bus1.ce = ce;  assign bus1.in_valid = vld;  assign bus1.acc_clr = clr;
  assign bus2.ce = ce;  assign bus2.in_valid = vld;  assign bus2.acc_clr = clr;
  assign bus0.a = in_a[0][20:0];  assign bus0.b = in_b[0][13:0];
  assign bus1.a = in_a[1][7:0];   assign bus1.b = in_b[1][7:0];
  assign bus2.a = in_a[2][7:0];   assign bus2.b = in_b[2][7:0];

  mpc_mac_pipe_dsp u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  mpc_mac_pipe_dsp #(
    .A_W(8), .B_W(8), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .MAC_EN(1'b1),
    .GUARD(0), .SHIFT(0), .OUT_W(20), .PIPE_X(2)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  mpc_mac_pipe_dsp #(
    .A_W(8), .B_W(8), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .MAC_EN(1'b0),
    .GUARD(4), .SHIFT(4), .OUT_W(8), .PIPE_X(1)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic signed [63:0] obs_p [3];
  logic               obs_v [3];
  logic               obs_s [3];
  logic               obs_o [3];

  assign obs_p[0] = 64'(bus0.p);  assign obs_v[0] = bus0.out_valid;
  assign obs_s[0] = bus0.sat;     assign obs_o[0] = bus0.acc_ovf;
  assign obs_p[1] = 64'(bus1.p);  assign obs_v[1] = bus1.out_valid;
  assign obs_s[1] = bus1.sat;     assign obs_o[1] = bus1.acc_ovf;
  assign obs_p[2] = 64'(bus2.p);  assign obs_v[2] = bus2.out_valid;
  assign obs_s[2] = bus2.sat;     assign obs_o[2] = bus2.acc_ovf;

  typedef struct {
    longint due;
    longint p;
    bit     s;
    bit     o;
  } exp_t;

  exp_t   exp_q [3][$];
  longint m_acc [3];
  bit     m_ovf [3];
  longint m_cnt [3];
  bit     e_v   [3];
  longint e_p   [3];
  bit     e_s   [3];
  bit     e_o   [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint wrap_s(input longint x, input int w);
    longint m = 64'sd1 <<< w;
    longint y = x & (m - 1);
    if (y >= (m >>> 1)) y -= m;
    return y;
  endfunction

  function automatic longint as_val(input logic [31:0] raw, input int w, input int sgn);
    longint v = longint'(raw);
    if (sgn != 0 && v >= (64'sd1 <<< (w - 1))) v -= (64'sd1 <<< w);
    return v;
  endfunction

  task automatic model_edge(input int k);
    if (rst) begin
      exp_q[k].delete();
      m_acc[k] = 0;  m_ovf[k] = 0;  m_cnt[k] = 0;
      e_v[k] = 0;    e_p[k] = 0;    e_s[k] = 0;  e_o[k] = 0;
    end else if (ce) begin
      m_cnt[k]++;
      if (vld) begin
        longint pr, pw, sum, r, hi, lo;
        exp_t   e;
        pr = as_val(in_a[k], c_aw[k], c_as[k]) * as_val(in_b[k], c_bw[k], c_bs[k]);
        pw = wrap_s(pr, c_accw[k]);
        if (c_mac[k] == 0 || clr) begin
          m_acc[k] = pw;
          m_ovf[k] = (c_mac[k] != 0) && (pw != pr);
        end else begin
          sum      = m_acc[k] + pw;
          m_acc[k] = wrap_s(sum, c_accw[k]);
          m_ovf[k] = m_ovf[k] || (pw != pr) || (m_acc[k] != sum);
        end
        r  = (m_acc[k] + ((c_sh[k] > 0) ? (64'sd1 <<< (c_sh[k] - 1)) : 64'sd0)) >>> c_sh[k];
        hi = (64'sd1 <<< (c_ow[k] - 1)) - 1;
        lo = -hi - 1;
        e.s = 1'b0;
        if (r > hi) begin r = hi; e.s = 1'b1; end
        else if (r < lo) begin r = lo; e.s = 1'b1; end
        e.p   = r;
        e.o   = m_ovf[k];
        e.due = m_cnt[k] + c_lat[k] - 1;
        exp_q[k].push_back(e);
      end
      e_v[k] = 0;
      if (exp_q[k].size() > 0 && exp_q[k][0].due == m_cnt[k]) begin
        e_v[k] = 1;
        e_p[k] = exp_q[k][0].p;
        e_s[k] = exp_q[k][0].s;
        e_o[k] = exp_q[k][0].o;
        void'(exp_q[k].pop_front());
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("u%0d.out_valid", k), obs_v[k], e_v[k]);
      check_val($sformatf("u%0d.p", k),         obs_p[k], e_p[k]);
      check_val($sformatf("u%0d.sat", k),       obs_s[k], e_s[k]);
      check_val($sformatf("u%0d.acc_ovf", k),   obs_o[k], e_o[k]);
    end
  endtask

  task automatic drive(input bit v, input bit c, input longint a, input longint b);
    vld = v;
    clr = c;
    for (int k = 0; k < 3; k++) begin
      in_a[k] = 32'(a) & 32'((64'sd1 <<< c_aw[k]) - 64'sd1);
      in_b[k] = 32'(b) & 32'((64'sd1 <<< c_bw[k]) - 64'sd1);
    end
  endtask

  task automatic drive_rand(input bit v, input bit c);
    vld = v;
    clr = c;
    for (int k = 0; k < 3; k++) begin
      in_a[k] = $urandom() & 32'((64'sd1 <<< c_aw[k]) - 64'sd1);
      in_b[k] = $urandom() & 32'((64'sd1 <<< c_bw[k]) - 64'sd1);
    end
  endtask

  task automatic bubbles(input int n);
    drive(1'b0, 1'b0, 0, 0);
    repeat (n) cycle();
  endtask

  int lat_n;

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    repeat (3) cycle();
    rst = 1'b0;

    // full-scale operands on the default multiplier
    drive(1'b1, 1'b0, -1048576, 16383);  cycle();
    drive(1'b1, 1'b0, 1048575, 16383);   cycle();
    bubbles(8);

    // running sum 12, 42, 28
    drive(1'b1, 1'b1, 3, 4);   cycle();
    drive(1'b1, 1'b0, 5, 6);   cycle();
    drive(1'b1, 1'b0, -2, 7);  cycle();
    bubbles(8);

    // rounding and both clamp directions
    drive(1'b1, 1'b0, 3, 3);      cycle();
    drive(1'b1, 1'b0, 127, 127);  cycle();
    drive(1'b1, 1'b0, -128, 127); cycle();
    bubbles(8);

    // accumulator wrap with no guard bits, then recovery on clear
    drive(1'b1, 1'b1, 127, 127);  cycle();
    drive(1'b1, 1'b0, 127, 127);  cycle();
    cycle();
    bubbles(8);
    check_val("u1.ovf_after_wrap", obs_o[1], 1);
    drive(1'b1, 1'b1, 1, 1);      cycle();
    bubbles(8);
    check_val("u1.ovf_after_clr", obs_o[1], 0);
    check_val("u1.p_after_clr", obs_p[1], 1);

    // ten-sample burst with ce alternating every cycle
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1, (i == 0));
      ce = 1'b0;  cycle();
      ce = 1'b1;  cycle();
    end
    drive(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      ce = i[0];
      cycle();
    end
    ce = 1'b1;
    bubbles(4);

    // reset with samples in flight, then first-sample latency
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, 0, 0);
    rst = 1'b1;  cycle();
    rst = 1'b0;
    bubbles(8);
    drive(1'b1, 1'b1, 2, 3);
    lat_n = 0;
    do begin
      cycle();
      lat_n++;
      drive(1'b0, 1'b0, 0, 0);
    end while (!obs_v[1] && lat_n < 20);
    check_val("u1.latency", lat_n, 6);
    bubbles(8);

    // randomized traffic with stalls, bubbles, clears and the odd reset
    for (int i = 0; i < 3000; i++) begin
      ce  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      drive_rand($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);
      cycle();
    end
    rst = 1'b0;
    ce  = 1'b1;
    bubbles(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
